// File: rtl/bitwise_op_stage_if.sv
// Handshake bundle for bitwise_op_stage.
//   master (upstream/downstream side): drives in_valid, op, a, b, out_ready
//   slave  (the stage):                 drives in_ready, out_valid, result, zero
interface bitwise_op_stage_if #(
    parameter int unsigned SIZE = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      op;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] result;
    logic            zero;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/bitwise_op_stage.sv
// Registered bitwise-logic stage (NOT/AND/OR/XOR) with a 2-entry output FIFO.
//   clk       rising-edge clock
//   rst_b     asynchronous active-low reset
//   bus       slave side of bitwise_op_stage_if (operand in, result out)
//   ops_done  wrapping count of results consumed downstream
module bitwise_op_stage #(
    parameter int unsigned SIZE  = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_b,
    bitwise_op_stage_if.slave   bus,
    output logic [CNT_W-1:0]    ops_done
);

    // Buffer occupancy doubles as the FSM state.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam logic [1:0] OP_NOT = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    logic [1:0]            count_q,     count_d;
    logic                  wr_ptr_q,    wr_ptr_d;
    logic                  rd_ptr_q,    rd_ptr_d;
    logic [1:0][SIZE-1:0]  mem_q,       mem_d;
    logic                  in_ready_q,  in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [SIZE-1:0]       result_q,    result_d;
    logic                  zero_q,      zero_d;
    logic [CNT_W-1:0]      ops_done_q,  ops_done_d;

    logic                  push;
    logic                  pop;
    logic [SIZE-1:0]       op_res;

    // State and output registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            count_q     <= ST_EMPTY;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            mem_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            ops_done_q  <= '0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_q       <= mem_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            ops_done_q  <= ops_done_d;
        end
    end

    // Next-state, buffer update and next registered outputs.
    always_comb begin
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_d      = mem_q;
        ops_done_d = ops_done_q;
        op_res     = '0;

        // Handshakes use only registered flags, so no in->out combinational path.
        push = bus.in_valid && in_ready_q;
        pop  = out_valid_q && bus.out_ready;

        case (bus.op)
            OP_NOT:  op_res = ~bus.a;
            OP_AND:  op_res = bus.a & bus.b;
            OP_OR:   op_res = bus.a | bus.b;
            OP_XOR:  op_res = bus.a ^ bus.b;
            default: op_res = '0;
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = op_res;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d   = ~rd_ptr_q;
            ops_done_d = ops_done_q + CNT_W'(1);
        end

        case (count_q)
            ST_EMPTY: if (push) count_d = ST_ONE;
            ST_ONE: begin
                if (push && !pop)      count_d = ST_FULL;
                else if (pop && !push) count_d = ST_EMPTY;
            end
            ST_FULL:  if (pop) count_d = ST_ONE;
            default:  count_d = ST_EMPTY;
        endcase

        // Head of the next-cycle buffer; covers the push-into-empty and
        // push-and-pop cases because mem_d already holds the new entry.
        in_ready_d  = (count_d != ST_FULL);
        out_valid_d = (count_d != ST_EMPTY);
        result_d    = out_valid_d ? mem_d[rd_ptr_d] : '0;
        zero_d      = out_valid_d && (result_d == '0);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign ops_done      = ops_done_q;

endmodule

// File: tb/tb_bitwise_op_stage.sv
// Bench for bitwise_op_stage: queue-based reference model checked every cycle,
// plus directed literal checks for the documented scenarios.
module tb_bitwise_op_stage;

    localparam int unsigned SIZE  = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst_b;
    logic [CNT_W-1:0] ops_done;

    bitwise_op_stage_if #(.SIZE(SIZE)) bus ();

    bitwise_op_stage #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .bus      (bus.slave),
        .ops_done (ops_done)
    );

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: results waiting downstream, in order, and consumed count.
    logic [SIZE-1:0]  m_q[$];
    logic [CNT_W-1:0] m_cnt;

    function automatic logic [SIZE-1:0] f_op(input logic [1:0] o, input logic [SIZE-1:0] x,
                                              input logic [SIZE-1:0] y);
        case (o)
            2'b00:   return ~x;
            2'b01:   return x & y;
            2'b10:   return x | y;
            default: return x ^ y;
        endcase
    endfunction

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            m_q.delete();
            m_cnt = '0;
        end else begin
            logic do_push, do_pop;
            logic [SIZE-1:0] v;
            do_push = bus.in_valid && (m_q.size() < 2);
            do_pop  = bus.out_ready && (m_q.size() > 0);
            v       = f_op(bus.op, bus.a, bus.b);
            if (do_pop) begin
                void'(m_q.pop_front());
                m_cnt = m_cnt + 1'b1;
            end
            if (do_push) m_q.push_back(v);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic [SIZE-1:0] exp_res;
        exp_res = (m_q.size() != 0) ? m_q[0] : '0;
        chk("m_out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
        chk("m_in_ready",  32'(bus.in_ready),  32'(m_q.size() < 2));
        chk("m_result",    32'(bus.result),    32'(exp_res));
        chk("m_zero",      32'(bus.zero),      32'((m_q.size() != 0) && (exp_res == '0)));
        chk("m_ops_done",  32'(ops_done),      32'(m_cnt));
    end

    task automatic drive(input logic iv, input logic [1:0] o, input logic [7:0] aa,
                         input logic [7:0] bb, input logic ordy);
        bus.in_valid  = iv;
        bus.op        = o;
        bus.a         = aa;
        bus.b         = bb;
        bus.out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        repeat (2) tick();
        rst_b = 1'b1;
        tick();
    endtask

    initial begin
        rst_b = 1'b0;
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        repeat (2) tick();

        // Reset values.
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_ops_done",  32'(ops_done),      32'd0);
        chk("rst_result",    32'(bus.result),    32'd0);
        chk("rst_zero",      32'(bus.zero),      32'd0);
        rst_b = 1'b1;
        tick();

        // NOT latency.
        drive(1'b1, 2'b00, 8'b10101010, 8'hFF, 1'b1);
        tick();
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
        chk("not_valid",  32'(bus.out_valid), 32'd1);
        chk("not_result", 32'(bus.result),    32'h55);
        chk("not_zero",   32'(bus.zero),      32'd0);
        chk("not_cnt0",   32'(ops_done),      32'd0);
        tick();
        chk("not_cnt1",   32'(ops_done),      32'd1);
        chk("not_empty",  32'(bus.out_valid), 32'd0);

        // Backpressure.
        drive(1'b1, 2'b01, 8'hCC, 8'hF0, 1'b0);
        tick();
        drive(1'b1, 2'b10, 8'h0F, 8'hF0, 1'b0);
        tick();
        chk("bp_full", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 2'b11, 8'h01, 8'h01, 1'b0);
        repeat (2) tick();
        chk("bp_held_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_head0",      32'(bus.result),   32'hC0);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_head1", 32'(bus.result), 32'hFF);
        tick();
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        chk("bp_xor_res",  32'(bus.result), 32'h00);
        chk("bp_xor_zero", 32'(bus.zero),   32'd1);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_cnt", 32'(ops_done), 32'd4);

        // Simultaneous push and pop with one entry buffered.
        drive(1'b1, 2'b10, 8'h30, 8'h03, 1'b0);
        tick();
        chk("sim_head0", 32'(bus.result), 32'h33);
        drive(1'b1, 2'b11, 8'hFF, 8'h0F, 1'b1);
        tick();
        chk("sim_head1",  32'(bus.result),    32'hF0);
        chk("sim_valid",  32'(bus.out_valid), 32'd1);
        chk("sim_ready",  32'(bus.in_ready),  32'd1);
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
        tick();
        chk("sim_empty", 32'(bus.out_valid), 32'd0);
        chk("sim_cnt",   32'(ops_done),      32'd6);

        // Counter wrap and pointer wrap over repeated fill/drain rounds.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'(i), 8'(i * 37), 8'(8'hA5 ^ i), 1'b0);
            tick();
            drive(1'b1, 2'(i + 1), 8'(i * 11 + 3), 8'(8'h5A + i), 1'b0);
            tick();
            drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
            repeat (2) tick();
        end
        chk("wrap_cnt16", 32'(ops_done), 32'd0);
        drive(1'b1, 2'b01, 8'h00, 8'hFF, 1'b1);
        tick();
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
        chk("wrap_zero", 32'(bus.zero), 32'd1);
        tick();
        chk("wrap_cnt17", 32'(ops_done), 32'd1);

        // Mid-operation asynchronous reset with a full buffer.
        drive(1'b1, 2'b00, 8'h12, 8'h00, 1'b0);
        tick();
        drive(1'b1, 2'b10, 8'h40, 8'h04, 1'b0);
        tick();
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        chk("mr_full", 32'(bus.in_ready), 32'd0);
        #2;
        rst_b = 1'b0;
        #1;
        chk("mr_valid_now", 32'(bus.out_valid), 32'd0);
        chk("mr_ready_now", 32'(bus.in_ready),  32'd1);
        chk("mr_cnt_now",   32'(ops_done),      32'd0);
        #1;
        rst_b = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        chk("mr_no_stale", 32'(bus.out_valid), 32'd0);
        chk("mr_cnt_after", 32'(ops_done),     32'd0);

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
